// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU datapath selectors: the storage-state
// encoding of the skid-buffered pipeline stage and a width helper.
package cpu_pkg;

    // Occupancy of the main (M) and skid (S) registers.
    localparam logic [1:0] ST_EMPTY = 2'd0;  // neither register holds a beat
    localparam logic [1:0] ST_ONE   = 2'd1;  // M holds a beat, S is free
    localparam logic [1:0] ST_FULL  = 2'd2;  // M and S both hold beats

    // Width needed to encode n values, never less than one bit so that
    // a degenerate select still produces a legal vector.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_n_w_comb.sv
// Purely combinational N:1, WIDTH-bit selector. A select value with no
// matching input yields zero data and raises err.
module mux_n_w_comb
    import cpu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    localparam int SEL_W = clog2_min1(NUM_IN)
) (
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    output logic [WIDTH-1:0]        sel_data,
    output logic                    err
);

    // Unflattened view of the inputs: in_arr[k] is input k.
    logic [WIDTH-1:0] in_arr [NUM_IN];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_IN; gi++) begin : g_unpack
            assign in_arr[gi] = in_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // One-hot style compare against every legal index; no match means the
    // select is out of range, which leaves data at zero and flags err.
    always_comb begin
        sel_data = '0;
        err      = 1'b1;
        for (int k = 0; k < NUM_IN; k++) begin
            if (in_sel == SEL_W'(k)) begin
                sel_data = in_arr[k];
                err      = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mux_n_w_pipe.sv
// N:1 WIDTH-bit selector followed by a registered valid/ready stage with a
// one-entry skid buffer. in_ready comes straight from a flop, so there is no
// combinational path from out_ready back to in_ready, yet the stage still
// sustains one beat per cycle.
module mux_n_w_pipe
    import cpu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    localparam int SEL_W = clog2_min1(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_err,
    output logic                    out_valid,
    input  logic                    out_ready
);

    logic [WIDTH-1:0] sel_data;
    logic             sel_err;

    mux_n_w_comb #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN)
    ) u_sel (
        .in_data  (in_data),
        .in_sel   (in_sel),
        .sel_data (sel_data),
        .err      (sel_err)
    );

    logic [1:0]       state_q,    state_d;
    logic             in_ready_q, in_ready_d;
    logic [WIDTH-1:0] m_data_q,   m_data_d;
    logic [SEL_W-1:0] m_sel_q,    m_sel_d;
    logic             m_err_q,    m_err_d;
    logic [WIDTH-1:0] s_data_q,   s_data_d;
    logic [SEL_W-1:0] s_sel_q,    s_sel_d;
    logic             s_err_q,    s_err_d;

    logic in_xfer;
    logic out_xfer;

    // M drives the outputs directly; it is valid whenever the stage is not empty.
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = m_data_q;
    assign out_sel   = m_sel_q;
    assign out_err   = m_err_q;
    assign in_ready  = in_ready_q;

    assign in_xfer  = in_valid && in_ready_q;
    assign out_xfer = out_valid && out_ready;

    // Next-state and register-load decisions for the M/S pair.
    always_comb begin
        state_d  = state_q;
        m_data_d = m_data_q;
        m_sel_d  = m_sel_q;
        m_err_d  = m_err_q;
        s_data_d = s_data_q;
        s_sel_d  = s_sel_q;
        s_err_d  = s_err_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_xfer) begin
                    m_data_d = sel_data;
                    m_sel_d  = in_sel;
                    m_err_d  = sel_err;
                    state_d  = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_xfer && out_xfer) begin
                    // M drains and refills in the same edge: no bubble.
                    m_data_d = sel_data;
                    m_sel_d  = in_sel;
                    m_err_d  = sel_err;
                end else if (out_xfer) begin
                    state_d = ST_EMPTY;
                end else if (in_xfer) begin
                    // Downstream stalled while upstream still had a beat in
                    // flight (in_ready was already 1): park it in S.
                    s_data_d = sel_data;
                    s_sel_d  = in_sel;
                    s_err_d  = sel_err;
                    state_d  = ST_FULL;
                end
            end
            ST_FULL: begin
                // in_ready is 0 here, so only the output side can move.
                if (out_xfer) begin
                    m_data_d = s_data_q;
                    m_sel_d  = s_sel_q;
                    m_err_d  = s_err_q;
                    state_d  = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        in_ready_d = (state_d != ST_FULL);
    end

    // State and data registers; reset also clears data so out_data reads 0
    // until the first beat is loaded.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
            m_data_q   <= '0;
            m_sel_q    <= '0;
            m_err_q    <= 1'b0;
            s_data_q   <= '0;
            s_sel_q    <= '0;
            s_err_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            m_data_q   <= m_data_d;
            m_sel_q    <= m_sel_d;
            m_err_q    <= m_err_d;
            s_data_q   <= s_data_d;
            s_sel_q    <= s_sel_d;
            s_err_q    <= s_err_d;
        end
    end

endmodule

// File: tb/tb_mux_n_w_pipe.sv
// Bench for mux_n_w_pipe: two instances (NUM_IN=4 and NUM_IN=3) share the
// same stimulus; each has its own scoreboard queue fed on input transfers
// and drained on output transfers.
module tb_mux_n_w_pipe;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  sel;
        logic        err;
    } beat_t;

    logic         clk;
    logic         rst;
    logic [127:0] in_data;
    logic [1:0]   in_sel;
    logic         in_valid;
    logic         out_ready;

    logic        ov [2];
    logic        ir [2];
    logic [31:0] od [2];
    logic [1:0]  os [2];
    logic        oe [2];

    beat_t q0[$];
    beat_t q1[$];

    int checks = 0;
    int errors = 0;

    mux_n_w_pipe #(.WIDTH(32), .NUM_IN(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (ir[0]),
        .out_data  (od[0]),
        .out_sel   (os[0]),
        .out_err   (oe[0]),
        .out_valid (ov[0]),
        .out_ready (out_ready)
    );

    mux_n_w_pipe #(.WIDTH(32), .NUM_IN(3)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data[95:0]),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (ir[1]),
        .out_data  (od[1]),
        .out_sel   (os[1]),
        .out_err   (oe[1]),
        .out_valid (ov[1]),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic beat_t model(input int n, input logic [127:0] d, input logic [1:0] s);
        beat_t b;
        b.sel = s;
        if (int'(s) < n) begin
            b.data = d[int'(s)*32 +: 32];
            b.err  = 1'b0;
        end else begin
            b.data = 32'd0;
            b.err  = 1'b1;
        end
        return b;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Pop and compare one output beat of DUT d if it transfers this edge.
    task automatic score_out(input int d);
        beat_t got;
        beat_t e;
        got.data = od[d];
        got.sel  = os[d];
        got.err  = oe[d];
        if (ov[d] && out_ready) begin
            if ((d == 0 ? q0.size() : q1.size()) == 0) begin
                checks++;
                errors++;
                $error("FAIL sb_extra_beat dut%0d got=%h exp=none", d, got);
            end else begin
                if (d == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                checks++;
                assert (got === e) else begin
                    errors++;
                    $error("FAIL sb_beat dut%0d got=%h exp=%h", d, got, e);
                end
            end
        end
    endtask

    // One clock: update scoreboards at the negedge (inputs are stable),
    // then advance past the posedge.
    task automatic step();
        @(negedge clk);
        if (!rst) begin
            score_out(0);
            score_out(1);
            if (in_valid && ir[0]) q0.push_back(model(4, in_data, in_sel));
            if (in_valid && ir[1]) q1.push_back(model(3, in_data, in_sel));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_chk(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk({tag, "_out_valid"}, 64'(ov[d]), 64'd0);
            chk({tag, "_in_ready"},  64'(ir[d]), 64'd1);
        end
    endtask

    logic [31:0] word_a;
    logic [31:0] word_b;

    initial begin
        rst       = 1'b1;
        in_data   = '0;
        in_sel    = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // 1. Reset and idle
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idle_chk("rst_idle");
            chk("rst_out_data4", 64'(od[0]), 64'd0);
            chk("rst_out_data3", 64'(od[1]), 64'd0);
            step();
        end

        // 2. Streaming select, one beat per cycle
        in_data   = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_sel = 2'(i);
            step();
            chk("stream_valid", 64'(ov[0]), 64'd1);
            chk("stream_data",  64'(od[0]), 64'(32'h11111111 * (i + 1)));
            chk("stream_sel",   64'(os[0]), 64'(i));
            chk("stream_ready", 64'(ir[0]), 64'd1);
        end
        in_valid = 1'b0;
        step();
        chk("stream_drained", 64'(ov[0]), 64'd0);

        // 3. Backpressure: A then B with out_ready low
        word_a    = 32'hA5A5_0001;
        word_b    = 32'h5A5A_0002;
        in_data   = {32'h0, 32'h0, word_b, word_a};
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sel    = 2'd0;
        step();
        chk("bp_ready_after_a", 64'(ir[0]), 64'd1);
        in_sel = 2'd1;
        step();
        in_valid = 1'b0;
        chk("bp_hold_data",  64'(od[0]), 64'(word_a));
        chk("bp_full_ready", 64'(ir[0]), 64'd0);
        chk("bp_full_ready3", 64'(ir[1]), 64'd0);
        step();
        chk("bp_stable_data", 64'(od[0]), 64'(word_a));
        chk("bp_stable_ready", 64'(ir[0]), 64'd0);
        out_ready = 1'b1;
        step();
        chk("bp_b_data",   64'(od[0]), 64'(word_b));
        chk("bp_b_valid",  64'(ov[0]), 64'd1);
        chk("bp_ready_back", 64'(ir[0]), 64'd1);
        step();
        chk("bp_drained", 64'(ov[0]), 64'd0);

        // 4. Out-of-range select on the 3-input instance
        in_data  = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
        in_valid = 1'b1;
        in_sel   = 2'd3;
        step();
        chk("oor_data3", 64'(od[1]), 64'd0);
        chk("oor_err3",  64'(oe[1]), 64'd1);
        chk("oor_sel3",  64'(os[1]), 64'd3);
        chk("oor_data4", 64'(od[0]), 64'(32'hDDDD_0003));
        chk("oor_err4",  64'(oe[0]), 64'd0);
        in_sel = 2'd1;
        step();
        chk("after_oor_data3", 64'(od[1]), 64'(32'hBBBB_0001));
        chk("after_oor_err3",  64'(oe[1]), 64'd0);
        in_valid = 1'b0;
        step();

        // 5. Reset while FULL with in_valid high
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sel    = 2'd0;
        step();
        in_sel = 2'd2;
        step();
        chk("pre_rst_full", 64'(ir[0]), 64'd0);
        rst = 1'b1;
        step();
        q0.delete();
        q1.delete();
        rst      = 1'b0;
        in_valid = 1'b0;
        idle_chk("post_rst");
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_no_beat4", 64'(ov[0]), 64'd0);
            chk("post_rst_no_beat3", 64'(ov[1]), 64'd0);
        end

        // 6. Random soak against the scoreboards
        for (int i = 0; i < 10000; i++) begin
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            in_sel    = 2'($urandom_range(0, 3));
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (q0.size() != 0 || q1.size() != 0 || ov[0] || ov[1]) step();
        end
        chk("soak_left4", 64'(q0.size()), 64'd0);
        chk("soak_left3", 64'(q1.size()), 64'd0);
        chk("soak_idle4", 64'(ov[0]), 64'd0);
        chk("soak_idle3", 64'(ov[1]), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_n_w_pipe.md
Name: mux_n_w_pipe

Overview:
- Parametrised N-to-1, W-bit selector followed by a registered valid/ready pipeline stage with a one-entry skid buffer. Successor to the CPU's 2:1 combinational selectors.
- Used where operand selection sits on a stage boundary, e.g. forwarding/ALU-operand selection feeding EX, or the writeback-source select.
- Sustains one transfer per cycle under backpressure without a combinational ready path from output to input.

Parameters:
- WIDTH, 32, data width of each input and of the output.
- NUM_IN, 4, number of selectable inputs; legal range 2..16.
- SEL_W, $clog2(NUM_IN), select width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_data  input  NUM_IN*WIDTH  flattened inputs; input k occupies bits [k*WIDTH +: WIDTH].
- in_sel  input  SEL_W  binary select, sampled with in_data.
- in_valid  input  1  upstream has a beat.
- in_ready  output  1  stage can accept a beat; driven from a register.
- out_data  output  WIDTH  selected data, registered.
- out_sel  output  SEL_W  echo of the select that produced out_data.
- out_err  output  1  beat carried in_sel >= NUM_IN.
- out_valid  output  1  out_* hold a valid beat.
- out_ready  input  1  downstream accepts.

Behaviour:
- Reset:
  - rst is synchronous, active-high and dominates every other input.
  - After reset: out_valid=0, out_data=0, out_sel=0, out_err=0, in_ready=1, skid empty.
  - A beat in flight when reset is asserted is discarded.
- Handshake:
  - An input transfer occurs when in_valid && in_ready at a clock edge.
  - An output transfer occurs when out_valid && out_ready at a clock edge.
  - While out_valid=1 and out_ready=0, out_data, out_sel and out_err stay stable.
- Selection:
  - When in_sel < NUM_IN, sel_data = in_data[in_sel*WIDTH +: WIDTH] and err=0.
  - When in_sel >= NUM_IN (possible only when NUM_IN is not a power of 2), sel_data = 0 and err=1. The beat is still transferred normally.
- Latency: an accepted beat appears on out_* at the next edge if the main register is empty or draining. Zero bubbles at full throughput.
- Storage: main register M, which drives out_*, and skid register S. States are EMPTY, ONE (M only) and FULL (M and S).
  - EMPTY, input transfer: load M; go to ONE.
  - ONE, input transfer and output transfer: reload M; stay in ONE.
  - ONE, output transfer only: go to EMPTY.
  - ONE, input transfer only (out_ready=0): load S; go to FULL; in_ready becomes 0 next cycle.
  - FULL, output transfer: M <= S; go to ONE; in_ready becomes 1 next cycle.
  - FULL, no output transfer: hold.
  - in_ready = (state != FULL), registered. No input transfer can occur in FULL.
- Ordering: strictly FIFO. Beats are never dropped or duplicated.
- Data held in an empty register is don't-care internally, but out_data must read 0 while out_valid=0 after reset, until the first load.

Decomposition:
- Shared package cpu_pkg holds:
  - the state encoding localparams ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2;
  - the function clog2_min1, which returns at least 1.
- One sub-module, mux_n_w_comb: the purely combinational N:1 select with out-of-range detection (ports in_data, in_sel, sel_data, err). The top module instantiates it and adds the skid/pipeline logic.

Test Plan:
1. Reset and idle:
   - Stimulus: hold rst=1 for 2 cycles, then release with in_valid=0.
   - Required: out_valid=0, out_data=0, in_ready=1 on every cycle.
2. Streaming select (WIDTH=32, NUM_IN=4):
   - Stimulus: inputs = 0x11111111, 0x22222222, 0x33333333, 0x44444444; sel = 0,1,2,3 on consecutive cycles; out_ready=1.
   - Required: out_data equals the same sequence starting one cycle later, out_sel = 0,1,2,3, no bubbles.
3. Backpressure:
   - Stimulus: send A and B back-to-back with out_ready=0.
   - Required: out_data=A and in_ready=0 from the cycle after B is accepted.
   - Stimulus: raise out_ready for 2 cycles.
   - Required: A then B are delivered, and in_ready returns to 1 one cycle after A leaves.
4. Out-of-range select:
   - Stimulus: NUM_IN=3, in_sel=3.
   - Required: out_data=0, out_err=1, out_sel=3; a following beat with sel=1 returns input 1 with out_err=0.
5. Reset mid-operation:
   - Stimulus: get into FULL, then assert rst for 1 cycle while in_valid=1.
   - Required: no beat emerges; out_valid=0 and in_ready=1 the cycle after reset.
6. Random soak:
   - Stimulus: 10k cycles of random in_valid, out_ready and sel, checked against a reference queue model.
   - Required: output order and data match exactly; no loss and no duplication.
